norm_shift_ctrl: RTL and testbench

- Multi-cycle normalization controller for the multi-precision FMA back end.
- Accepts the 106-bit post-add mantissa and a precision mode, then finds the leading one in each lane.
- Left-shifts every lane concurrently in bounded steps until each lane's leading one reaches the lane MSB.
- Returns the normalized lanes with per-lane shift counts over valid/ready handshakes to the rounding stage.

---
 rtl/norm_shift_ctrl.sv | 133 +++++++++++++
 tb/tb_norm_shift_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/norm_shift_ctrl.sv
// norm_shift_ctrl: multi-lane leading-one normalizer with bounded per-cycle left shifts
module norm_shift_ctrl #(
    parameter int SHIFT_STEP = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_mode,
    input  logic [105:0] in_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   out_mode,
    output logic [105:0] out_data,
    output logic [27:0]  out_lzc,
    output logic [3:0]   out_zero
);
    typedef enum logic [1:0] {IDLE, DETECT, SHIFT, DONE} state_t;

    localparam logic [6:0] HP_LSB [4] = '{7'd78, 7'd50, 7'd22, 7'd0};
    localparam logic [6:0] HP_W   [4] = '{7'd28, 7'd28, 7'd28, 7'd22};
    localparam logic [6:0] SP_LSB [4] = '{7'd50, 7'd0, 7'd0, 7'd0};
    localparam logic [6:0] SP_W   [4] = '{7'd56, 7'd50, 7'd0, 7'd0};
    localparam logic [6:0] DP_W   [4] = '{7'd106, 7'd0, 7'd0, 7'd0};
    localparam logic [6:0] STEP = 7'(SHIFT_STEP);

    state_t       state, state_d;
    logic [1:0]   mode, mode_d;
    logic [105:0] data, data_d;
    logic [6:0]   rem [4];
    logic [6:0]   rem_d [4];
    logic [6:0]   lzc [4];
    logic [6:0]   lzc_d [4];
    logic [3:0]   zero, zero_d;
    logic [6:0]   lsb [4];
    logic [6:0]   w [4];
    logic [6:0]   clz [4];
    logic [6:0]   step [4];
    logic [105:0] mask [4];
    logic [105:0] shifted;
    logic         busy;

    function automatic logic [6:0] clz106(input logic [105:0] v);
        logic [6:0] n;
        n = 7'd106;
        for (int i = 0; i < 106; i++)
            if (v[i]) n = 7'(105 - i);
        return n;
    endfunction

    // lane geometry, per-lane leading-zero count (lane MSB aligned to bit 105) and bounded shift
    always_comb begin
        shifted = '0;
        for (int i = 0; i < 4; i++) begin
            lsb[i]  = mode == 2'b10 ? HP_LSB[i] : mode == 2'b01 ? SP_LSB[i] : 7'd0;
            w[i]    = mode == 2'b10 ? HP_W[i] : mode == 2'b01 ? SP_W[i] : DP_W[i];
            mask[i] = ((106'd1 << w[i]) - 106'd1) << lsb[i];
            clz[i]  = clz106((data & mask[i]) << (7'd106 - lsb[i] - w[i]));
            step[i] = rem[i] > STEP ? STEP : rem[i];
            shifted = shifted | (((data & mask[i]) << step[i]) & mask[i]);
        end
    end

    // next-state and datapath update; flush overrides everything and holds the datapath
    always_comb begin
        state_d = state;
        mode_d  = mode;
        data_d  = data;
        rem_d   = rem;
        lzc_d   = lzc;
        zero_d  = zero;
        busy    = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state_d = DETECT;
                    data_d  = in_data;
                    mode_d  = in_mode == 2'b11 ? 2'b00 : in_mode;
                end
                DETECT: begin
                    for (int i = 0; i < 4; i++) begin
                        zero_d[3-i] = w[i] != 7'd0 && clz[i] >= w[i];
                        lzc_d[i]    = clz[i] >= w[i] ? w[i] : clz[i];
                        rem_d[i]    = clz[i] >= w[i] ? 7'd0 : clz[i];
                        busy        = busy | (rem_d[i] != 7'd0);
                    end
                    state_d = busy ? SHIFT : DONE;
                end
                SHIFT: begin
                    data_d = shifted;
                    for (int i = 0; i < 4; i++) begin
                        rem_d[i] = rem[i] - step[i];
                        busy     = busy | (rem_d[i] != 7'd0);
                    end
                    state_d = busy ? SHIFT : DONE;
                end
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mode  <= 2'b00;
            data  <= '0;
            zero  <= '0;
            for (int i = 0; i < 4; i++) begin
                rem[i] <= '0;
                lzc[i] <= '0;
            end
        end else begin
            state <= state_d;
            mode  <= mode_d;
            data  <= data_d;
            zero  <= zero_d;
            rem   <= rem_d;
            lzc   <= lzc_d;
        end
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign out_mode  = mode;
    assign out_data  = data;
    assign out_zero  = zero;
    assign out_lzc   = {lzc[0], lzc[1], lzc[2], lzc[3]};
endmodule

// File: tb/tb_norm_shift_ctrl.sv
// tb_norm_shift_ctrl: table-driven scoreboard bench for norm_shift_ctrl
module tb_norm_shift_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;
    logic [1:0]   in_mode = 2'b00;
    logic [105:0] in_data = '0;
    logic         in_ready, out_valid;
    logic [1:0]   out_mode;
    logic [105:0] out_data;
    logic [27:0]  out_lzc;
    logic [3:0]   out_zero;
    int total = 0;
    int passed = 0;

    typedef struct {
        logic [1:0]   mode;
        logic [105:0] data;
        logic [105:0] e_data;
        logic [27:0]  e_lzc;
        logic [3:0]   e_zero;
        logic [1:0]   e_mode;
        int           e_lat;
    } vec_t;

    vec_t tv [8];
    vec_t exp_q [$];

    always #5 clk = ~clk;

    norm_shift_ctrl #(.SHIFT_STEP(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data),
        .out_lzc(out_lzc), .out_zero(out_zero)
    );

    task automatic chk(input string name, input logic [105:0] act, input logic [105:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, 106'(in_ready), 106'd1);
        chk({tag, "_out_valid"}, 106'(out_valid), 106'd0);
        chk({tag, "_out_data"}, out_data, 106'd0);
        chk({tag, "_out_lzc"}, 106'(out_lzc), 106'd0);
        chk({tag, "_out_zero"}, 106'(out_zero), 106'd0);
        chk({tag, "_out_mode"}, 106'(out_mode), 106'd0);
    endtask

    // Latency counts clock edges from the accept cycle: the accept edge is edge 1.
    task automatic run_vec(input vec_t v, input int hold);
        int n;
        vec_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_mode = v.mode;
        in_data = v.data;
        out_ready = hold == 0;
        chk("in_ready_idle", 106'(in_ready), 106'd1);
        exp_q.push_back(v);
        @(negedge clk);
        in_valid = 1'b0;
        in_data = '0;
        n = 1;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 106'(n), 106'(v.e_lat));
        repeat (hold) begin
            chk("hold_valid", 106'(out_valid), 106'd1);
            chk("hold_data", out_data, v.e_data);
            chk("hold_lzc", 106'(out_lzc), 106'(v.e_lzc));
            chk("hold_in_ready", 106'(in_ready), 106'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        if (exp_q.size() == 0) begin
            total++;
            $display("FAIL scoreboard: output with empty expectation queue");
        end else begin
            e = exp_q.pop_front();
            chk("out_valid", 106'(out_valid), 106'd1);
            chk("out_data", out_data, e.e_data);
            chk("out_lzc", 106'(out_lzc), 106'(e.e_lzc));
            chk("out_zero", 106'(out_zero), 106'(e.e_zero));
            chk("out_mode", 106'(out_mode), 106'(e.e_mode));
        end
        @(negedge clk);
        chk("release_in_ready", 106'(in_ready), 106'd1);
        chk("release_valid", 106'(out_valid), 106'd0);
    endtask

    initial begin
        int seen;
        tv[0] = '{2'b00, 106'd1 << 40, 106'd1 << 105, {7'd65, 21'd0}, 4'b0000, 2'b00, 5};
        tv[1] = '{2'b10, {28'h8000000, 28'h0000001, 28'h0000000, 22'h000100},
                  {28'h8000000, 28'h8000000, 28'h0000000, 22'h200000},
                  {7'd0, 7'd27, 7'd28, 7'd13}, 4'b0010, 2'b10, 3};
        tv[2] = '{2'b01, 106'd0, 106'd0, {7'd56, 7'd50, 14'd0}, 4'b1100, 2'b01, 2};
        tv[3] = '{2'b00, 106'd0, 106'd0, {7'd106, 21'd0}, 4'b1000, 2'b00, 2};
        tv[4] = '{2'b11, 106'd1, 106'd1 << 105, {7'd105, 21'd0}, 4'b0000, 2'b00, 6};
        tv[5] = '{2'b00, 106'd1 << 105, 106'd1 << 105, 28'd0, 4'b0000, 2'b00, 2};
        tv[6] = '{2'b01, {56'h1, 50'h3}, {56'h80000000000000, 50'h3000000000000},
                  {7'd55, 7'd48, 14'd0}, 4'b0000, 2'b01, 4};
        tv[7] = '{2'b10, {28'hFFFFFFF, 28'h0000003, 28'h4000000, 22'h000001},
                  {28'hFFFFFFF, 28'hC000000, 28'h8000000, 22'h200000},
                  {7'd0, 7'd26, 7'd1, 7'd21}, 4'b0000, 2'b10, 3};

        repeat (2) @(negedge clk);
        chk_reset_values("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(tv[i], i == 1 ? 4 : 0);

        // flush during the second SHIFT cycle of the DP 1<<40 word
        @(negedge clk);
        in_valid = 1'b1;
        in_mode = 2'b00;
        in_data = tv[0].data;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", 106'(in_ready), 106'd1);
        chk("flush_valid", 106'(out_valid), 106'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("flush_no_valid", 106'(seen), 106'd0);

        // flush coincident with an accept drops the word
        in_valid = 1'b1;
        in_data = tv[0].data;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush_accept_in_ready", 106'(in_ready), 106'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("flush_accept_no_valid", 106'(seen), 106'd0);
        run_vec(tv[0], 0);

        // asynchronous reset while in SHIFT
        @(negedge clk);
        in_valid = 1'b1;
        in_mode = tv[1].mode;
        in_data = tv[1].data;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_in_ready", 106'(in_ready), 106'd0);
        #2 rst_n = 1'b0;
        #1 chk_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen = 1;
        end
        chk("post_reset_idle", 106'(seen), 106'd0);
        run_vec(tv[2], 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
